nvram_store_recall: RTL
=======================

Name: nvram_store_recall

Overview:
- Emulates the board's X2212-style 256x4 NOVRAM pair downstream of the coin/counter output latch.
- Consumes the latch's STORE and RECALLn lines.
- Holds a CPU-visible working RAM and a non-volatile shadow array, and sequences bulk copies between them: RECALL copies shadow to RAM, STORE copies RAM to shadow.
- A host port gives the framework save/load access to the shadow array.

Parameters:
- ADDR_W, 8, address width; array depth is 2^ADDR_W words.
- DATA_W, 4, word width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- STORE  in  1  store request level from the output latch; acts on the rising edge.
- RECALLn  in  1  recall request level from the output latch; acts on the falling edge.
- cpu_cs  in  1  NOVRAM select.
- cpu_we  in  1  write strobe, qualified by cpu_cs.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_din  in  DATA_W  CPU write data.
- cpu_dout  out  DATA_W  CPU read data.
- hs_addr  in  ADDR_W  host shadow address.
- hs_we  in  1  host shadow write.
- hs_din  in  DATA_W  host write data.
- hs_dout  out  DATA_W  host read data.
- busy  out  1  copy in progress.
- store_done  out  1  one-cycle pulse when a STORE copy completes.

Behaviour:
- Edge detect:
  - store_prev and recalln_prev are registered copies of the inputs. Their reset values are 0 and 1.
  - store_evt = STORE & ~store_prev.
  - recall_evt = ~RECALLn & recalln_prev.
  - Events are evaluated only in IDLE. Events arriving while busy are dropped, not queued.
- Power-up recall: the output latch resets RECALLn low, so recall_evt fires on the first clk after reset deasserts. This recall is required behaviour.
- FSM states and transitions:
  - IDLE: on recall_evt go to RECALL. Otherwise, on store_evt go to STORE.
  - If both events occur in the same cycle, RECALL wins and the store is discarded.
  - RECALL and STORE share one copy engine built on a counter cnt (ADDR_W+1 bits), reset at entry.
    - Cycle k (k = 0..2^ADDR_W-1): read the source array at address k.
    - Cycle k+1: write the destination array at address k.
    - Exit to IDLE after the final write, at cycle 2^ADDR_W. Total time in state is 2^ADDR_W+1 cycles (257 at default).
  - The copy engine never stalls.
- busy:
  - Registered; equals (state != IDLE).
  - Rises the cycle after the event is sampled.
  - Falls in the cycle IDLE is re-entered.
- store_done: asserted for exactly one cycle, coincident with busy falling, after a STORE only. Never after a RECALL.
- CPU port:
  - In IDLE, a write with cpu_cs & cpu_we writes the RAM.
  - cpu_dout is registered RAM[cpu_addr] with 1-cycle latency, updated every cycle.
  - While busy, CPU writes are ignored and cpu_dout is forced to all-ones.
- Host port:
  - hs_dout is registered shadow[hs_addr] with 1-cycle latency, always available.
  - hs_we writes the shadow except during STORE; there it is dropped.
  - During RECALL, host writes land but their effect on RAM is undefined.
- Reset values: state IDLE, cnt 0, busy 0, store_done 0, cpu_dout 0, hs_dout 0.
- Reset never clears RAM or shadow contents.
- Reset mid-copy: abort immediately to IDLE with no store_done. Words already copied stay copied.
- Address arithmetic wraps modulo 2^ADDR_W. cnt has one extra bit for termination.

Test Plan:
- Power-up recall:
  - Stimulus: preload shadow via host (addr 0x00=0x3, 0xFF=0xC), hold RECALLn=0, release reset.
  - Required: busy high for 257 cycles; then CPU reads 0x00->0x3 and 0xFF->0xC; no store_done.
- Store:
  - Stimulus: CPU writes RAM 0x10=0x5 and 0x11=0xA, then STORE 0->1.
  - Required: busy rises the next cycle; store_done pulses once after 257 cycles; host reads 0x10->0x5 and 0x11->0xA.
- Busy lockout:
  - Stimulus: during STORE, CPU writes 0x20=0x7 and host writes 0x30=0x1.
  - Required: cpu_dout=0xF while busy; afterwards RAM[0x20] and shadow[0x30] are unchanged.
- Simultaneous events:
  - Stimulus: STORE rise and RECALLn fall in the same cycle.
  - Required: a RECALL runs, no store_done; a STORE toggle mid-recall produces no later store.
- Reset mid-store:
  - Stimulus: assert reset at copy cycle 100.
  - Required: busy=0 and store_done=0 immediately; shadow addresses below 99 hold the new data, addresses above hold the old data; RAM is unchanged.
- Level held:
  - Stimulus: STORE held high across two copy periods.
  - Required: exactly one store_done.

Source files
------------

// File: rtl/nvram_store_recall.sv
// X2212-style NOVRAM emulation: working RAM plus shadow array with
// bulk STORE/RECALL copies and a host port onto the shadow.
module nvram_store_recall #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              STORE,
    input  logic              RECALLn,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic [ADDR_W-1:0] hs_addr,
    input  logic              hs_we,
    input  logic [DATA_W-1:0] hs_din,
    output logic [DATA_W-1:0] hs_dout,
    output logic              busy,
    output logic              store_done
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RECALL = 2'd1;
    localparam logic [1:0] S_STORE  = 2'd2;

    localparam logic [ADDR_W:0] CNT_LAST = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] ram_mem    [DEPTH];
    logic [DATA_W-1:0] shadow_mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              store_prev_q, store_prev_d;
    logic              recalln_prev_q, recalln_prev_d;
    logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
    logic [DATA_W-1:0] hs_dout_q, hs_dout_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              store_evt;
    logic              recall_evt;
    logic [ADDR_W-1:0] copy_rd_addr;
    logic [ADDR_W-1:0] copy_wr_addr;
    logic              copy_wr;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              sh_we;
    logic [ADDR_W-1:0] sh_waddr;
    logic [DATA_W-1:0] sh_wdata;

    assign store_evt    = STORE & ~store_prev_q;
    assign recall_evt   = ~RECALLn & recalln_prev_q;
    assign copy_rd_addr = cnt_q[ADDR_W-1:0];
    assign copy_wr_addr = copy_rd_addr - ADDR_W'(1);
    // Word k is read in cycle k and written in cycle k+1, so cycle 0 writes nothing.
    assign copy_wr      = (state_q != S_IDLE) && (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (recall_evt) begin
                    state_d = S_RECALL;
                end else if (store_evt) begin
                    state_d = S_STORE;
                end
            end
            default: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = (state_q == S_STORE);
                end else begin
                    cnt_d = cnt_q + (ADDR_W+1)'(1);
                end
            end
        endcase
    end

    always_comb begin
        busy_d         = (state_d != S_IDLE);
        store_prev_d   = STORE;
        recalln_prev_d = RECALLn;
        rd_data_d      = (state_q == S_RECALL) ? shadow_mem[copy_rd_addr]
                                               : ram_mem[copy_rd_addr];
        cpu_dout_d     = busy_d ? {DATA_W{1'b1}} : ram_mem[cpu_addr];
        hs_dout_d      = shadow_mem[hs_addr];
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = cpu_addr;
        ram_wdata = cpu_din;
        if (state_q == S_IDLE) begin
            ram_we = cpu_cs & cpu_we;
        end else if (state_q == S_RECALL) begin
            ram_we    = copy_wr;
            ram_waddr = copy_wr_addr;
            ram_wdata = rd_data_q;
        end
    end

    // Host writes are dropped only while STORE owns the shadow write port.
    always_comb begin
        sh_we    = hs_we;
        sh_waddr = hs_addr;
        sh_wdata = hs_din;
        if (state_q == S_STORE) begin
            sh_we    = copy_wr;
            sh_waddr = copy_wr_addr;
            sh_wdata = rd_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_waddr] <= ram_wdata;
        end
        if (sh_we) begin
            shadow_mem[sh_waddr] <= sh_wdata;
        end
        rd_data_q <= rd_data_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            store_prev_q   <= 1'b0;
            recalln_prev_q <= 1'b1;
            cpu_dout_q     <= '0;
            hs_dout_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            store_prev_q   <= store_prev_d;
            recalln_prev_q <= recalln_prev_d;
            cpu_dout_q     <= cpu_dout_d;
            hs_dout_q      <= hs_dout_d;
        end
    end

    assign busy       = busy_q;
    assign store_done = done_q;
    assign cpu_dout   = cpu_dout_q;
    assign hs_dout    = hs_dout_q;

endmodule
